// File: rtl/traffic_sensor_if.sv
// Detector inputs, traffic-present levels and vehicle counts of the sensor conditioner.
// dbg_state_* exposes each channel FSM: 0=IDLE, 1=Q_ON, 2=PRESENT, 3=Q_OFF.
interface traffic_sensor_if #(
    parameter int CNT_W = 8
);
    logic             car_a_raw;
    logic             car_b_raw;
    logic             clr_cnt;
    logic             TA;
    logic             TB;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic [1:0]       dbg_state_a;
    logic [1:0]       dbg_state_b;

    modport master (
        output car_a_raw, car_b_raw, clr_cnt,
        input  TA, TB, cnt_a, cnt_b, dbg_state_a, dbg_state_b
    );

    modport slave (
        input  car_a_raw, car_b_raw, clr_cnt,
        output TA, TB, cnt_a, cnt_b, dbg_state_a, dbg_state_b
    );
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Conditions two raw car-detector loops into clean TA/TB levels: 2-flop sync,
// tick-based debounce FSM, gap-out hold stretch and saturating vehicle counters.
module traffic_sensor_conditioner #(
    parameter int CLK_DIV    = 1000,
    parameter int DEB_TICKS  = 4,
    parameter int HOLD_TICKS = 8,
    parameter int CNT_W      = 8
) (
    input logic              clk,
    input logic              reset,
    traffic_sensor_if.slave  bus
);
    localparam int PW = (CLK_DIV > 1)    ? $clog2(CLK_DIV)        : 1;
    localparam int DW = (DEB_TICKS > 1)  ? $clog2(DEB_TICKS)      : 1;
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        Q_ON    = 2'd1,
        PRESENT = 2'd2,
        Q_OFF   = 2'd3
    } state_t;

    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync_s;
    logic [PW-1:0] pcnt;
    logic          tick;

    assign raw = {bus.car_b_raw, bus.car_a_raw};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= '0;
            sync_s <= '0;
        end else begin
            sync1  <= raw;
            sync_s <= sync1;
        end
    end

    assign tick = (pcnt == PW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + 1'b1;
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [DW-1:0]    dcnt;
        logic [DW-1:0]    dcnt_nxt;
        logic             inc;
        logic             det;
        logic [HW-1:0]    hold;
        logic [CNT_W-1:0] cnt;
        logic             present;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state <= IDLE;
                dcnt  <= '0;
            end else begin
                state <= state_nxt;
                dcnt  <= dcnt_nxt;
            end
        end

        // A level change while qualifying drops straight back; no partial credit.
        always_comb begin
            state_nxt = state;
            dcnt_nxt  = dcnt;
            inc       = 1'b0;
            case (state)
                IDLE: begin
                    if (sync_s[ch]) begin
                        state_nxt = Q_ON;
                        dcnt_nxt  = '0;
                    end
                end
                Q_ON: begin
                    if (!sync_s[ch]) begin
                        state_nxt = IDLE;
                    end else if (tick) begin
                        if (dcnt == DW'(DEB_TICKS - 1)) begin
                            state_nxt = PRESENT;
                            inc       = 1'b1;
                        end else begin
                            dcnt_nxt = dcnt + 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (!sync_s[ch]) begin
                        state_nxt = Q_OFF;
                        dcnt_nxt  = '0;
                    end
                end
                Q_OFF: begin
                    if (sync_s[ch]) begin
                        state_nxt = PRESENT;
                    end else if (tick) begin
                        if (dcnt == DW'(DEB_TICKS - 1)) state_nxt = IDLE;
                        else                            dcnt_nxt  = dcnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        assign det = (state == PRESENT) || (state == Q_OFF);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset)                   hold <= '0;
            else if (det)                 hold <= HW'(HOLD_TICKS);
            else if (tick && hold != '0)  hold <= hold - 1'b1;
        end

        assign present = det | (hold != '0);

        // Clear takes priority over a same-cycle increment.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)                   cnt <= '0;
            else if (bus.clr_cnt)         cnt <= '0;
            else if (inc && cnt != '1)    cnt <= cnt + 1'b1;
        end
    end

    assign bus.TA          = g_ch[0].present;
    assign bus.TB          = g_ch[1].present;
    assign bus.cnt_a       = g_ch[0].cnt;
    assign bus.cnt_b       = g_ch[1].cnt;
    assign bus.dbg_state_a = g_ch[0].state;
    assign bus.dbg_state_b = g_ch[1].state;
endmodule
